// File: rtl/mmu_banked.sv
// mmu_banked: decodes a flat address space into SRAM, ROM and a byte-wide I/O
// port, moving 1..DATA_BYTES bytes per transaction, one byte per cycle,
// little-endian packed, with error reporting and abort on request drop.
module mmu_banked #(
    parameter int ADDR_W      = 24,
    parameter int DATA_BYTES  = 4,
    parameter int SRAM_AW     = 8,
    parameter int ROM_AW      = 8,
    parameter int REGION_LSB  = 8,
    parameter     ROM_FILE    = "rom.mem",
    parameter int IO_TIMEOUT  = 15,
    localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1,
    localparam int DW = DATA_BYTES * 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [CW-1:0]     byteCount,
    input  logic [DW-1:0]     dataIn,
    output logic [DW-1:0]     dataOut,
    output logic              dataOutReady,
    output logic              dataInReady,
    output logic              err,
    output logic              busy,
    output logic [7:0]        io_addr,
    output logic [7:0]        io_wdata,
    output logic              io_re,
    output logic              io_we,
    input  logic [7:0]        io_rdata,
    input  logic              io_ack
);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

    localparam logic [1:0] R_SRAM = 2'b00;
    localparam logic [1:0] R_ROM  = 2'b01;
    localparam logic [1:0] R_IO   = 2'b10;
    localparam logic [1:0] R_NONE = 2'b11;
    localparam int OW      = (REGION_LSB > 8) ? REGION_LSB : 8;
    localparam int TW      = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
    localparam int TO_LAST = (IO_TIMEOUT > 0) ? IO_TIMEOUT - 1 : 0;

    state_t                state, state_nxt;
    logic                  dir_rd;
    logic [1:0]            reg_r;
    logic [REGION_LSB-1:0] off_r;
    logic [CW-1:0]         cnt_r, idx;
    logic                  err_r;
    logic [TW-1:0]         wait_cnt;

    logic [OW-1:0] cur;
    logic          req_live, is_io, last, io_stb, timeout_hit;
    logic [7:0]    rbyte, wbyte;
    logic [1:0]    region_in;
    logic          unused_addr;

    logic [7:0] sram [2**SRAM_AW];
    logic [7:0] rom  [2**ROM_AW];

    // ROM bytes are zero
    initial begin
        for (int i = 0; i < 2**ROM_AW; i++) rom[i] = 8'h00;
    end

    assign region_in   = address[REGION_LSB+1:REGION_LSB];
    assign unused_addr = ^address[ADDR_W-1:REGION_LSB+2];
    // offset + n, truncated per region below so it never carries into region bits
    assign cur         = OW'(off_r) + OW'(idx);
    assign req_live    = dir_rd ? read : write;
    assign is_io       = (reg_r == R_IO);
    assign last        = (idx == cnt_r);
    assign io_stb      = io_re | io_we;
    assign timeout_hit = (IO_TIMEOUT != 0) && (wait_cnt == TW'(TO_LAST));
    assign rbyte       = (reg_r == R_ROM) ? rom[cur[ROM_AW-1:0]] : sram[cur[SRAM_AW-1:0]];
    assign wbyte       = dataIn[{idx, 3'b000} +: 8];

    assign busy         = (state == SETUP) || (state == XFER);
    assign dataOutReady = (state == DONE) && dir_rd;
    assign dataInReady  = (state == DONE) && !dir_rd;
    assign err          = (state == DONE) && err_r;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state; an errored request spends one dead XFER cycle so its pulse
    // lands at the same latency as a one-byte transfer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (read || write) state_nxt = SETUP;
            SETUP: state_nxt = req_live ? XFER : IDLE;
            XFER: begin
                if (!req_live) begin
                    state_nxt = IDLE;
                end else if (err_r) begin
                    state_nxt = DONE;
                end else if (!is_io) begin
                    if (last) state_nxt = DONE;
                end else if (io_stb && io_ack && last) begin
                    state_nxt = DONE;
                end else if (io_stb && !io_ack && timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // request latch, read data capture and I/O strobe sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut  <= '0;
            io_re    <= 1'b0;
            io_we    <= 1'b0;
            io_addr  <= 8'h00;
            io_wdata <= 8'h00;
            dir_rd   <= 1'b0;
            reg_r    <= 2'b00;
            off_r    <= '0;
            cnt_r    <= '0;
            idx      <= '0;
            err_r    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (read || write) begin
                    dir_rd  <= read;
                    reg_r   <= region_in;
                    off_r   <= address[REGION_LSB-1:0];
                    cnt_r   <= byteCount;
                    idx     <= '0;
                    dataOut <= '0;
                    err_r   <= (region_in == R_NONE) || (!read && region_in == R_ROM);
                end
                SETUP: if (req_live && !err_r && is_io) begin
                    io_re    <= dir_rd;
                    io_we    <= !dir_rd;
                    io_addr  <= cur[7:0];
                    io_wdata <= wbyte;
                    wait_cnt <= '0;
                end
                XFER: begin
                    if (!req_live) begin
                        io_re <= 1'b0;
                        io_we <= 1'b0;
                    end else if (!err_r) begin
                        if (!is_io) begin
                            if (dir_rd) dataOut[{idx, 3'b000} +: 8] <= rbyte;
                            idx <= idx + 1'b1;
                        end else if (io_stb) begin
                            if (io_ack) begin
                                if (dir_rd) dataOut[{idx, 3'b000} +: 8] <= io_rdata;
                                io_re <= 1'b0;
                                io_we <= 1'b0;
                                idx   <= idx + 1'b1;
                            end else if (timeout_hit) begin
                                io_re <= 1'b0;
                                io_we <= 1'b0;
                                err_r <= 1'b1;
                            end else begin
                                wait_cnt <= wait_cnt + 1'b1;
                            end
                        end else begin
                            // gap cycle over: present the next byte
                            io_re    <= dir_rd;
                            io_we    <= !dir_rd;
                            io_addr  <= cur[7:0];
                            io_wdata <= wbyte;
                            wait_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM byte write commits on the edge leaving byte n; aborts and reset skip it
    always_ff @(posedge clk) begin
        if (!rst && state == XFER && req_live && !err_r && reg_r == R_SRAM && !dir_rd)
            sram[cur[SRAM_AW-1:0]] <= wbyte;
    end

endmodule

// File: tb/tb_mmu_banked.sv
// tb_mmu_banked: directed vector table plus hand-written multi-cycle sequences.
module tb_mmu_banked;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] address;
    logic        read, write;
    logic [1:0]  byteCount;
    logic [31:0] dataIn, dataOut;
    logic        dataOutReady, dataInReady, err, busy;
    logic [7:0]  io_addr, io_wdata;
    logic        io_re, io_we;
    logic [7:0]  io_rdata = 8'h00;
    logic        io_ack = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mmu_banked dut (
        .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
        .byteCount(byteCount), .dataIn(dataIn), .dataOut(dataOut),
        .dataOutReady(dataOutReady), .dataInReady(dataInReady), .err(err),
        .busy(busy), .io_addr(io_addr), .io_wdata(io_wdata), .io_re(io_re),
        .io_we(io_we), .io_rdata(io_rdata), .io_ack(io_ack)
    );

    // I/O device model: acks after io_wait wait cycles, logs each accepted byte
    int         io_wait = 0;
    int         rd_base = 0;
    int         ack_n = 0;
    int         ws = 0;
    logic [7:0] rd_list [4];
    logic [7:0] addr_log [64];
    logic [7:0] wd_log [64];

    always @(posedge clk) begin
        #1;
        if ((io_re || io_we) && !io_ack) begin
            ws++;
            if (ws > io_wait) begin
                io_ack   = 1'b1;
                io_rdata = rd_list[(ack_n - rd_base) & 3];
                addr_log[ack_n & 63] = io_addr;
                wd_log[ack_n & 63]   = io_wdata;
                ack_n++;
            end
        end else begin
            io_ack = 1'b0;
            ws = 0;
        end
    end

    // err must only ever appear together with a ready pulse
    int orphan = 0;
    always @(negedge clk) begin
        if (err && !(dataOutReady || dataInReady)) orphan++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // one transaction: request starts at the next edge (E0); cyc is the k of E(k) after which the pulse is seen
    task automatic txn(input logic rd, input logic wr, input logic [23:0] a, input logic [1:0] bc,
                       input logic [31:0] d, output int cyc, output logic [31:0] dout,
                       output logic e, output logic prd, output logic pwr, output logic extra);
        read = rd; write = wr; address = a; byteCount = bc; dataIn = d;
        cyc = -1; dout = '0; e = 1'b0; prd = 1'b0; pwr = 1'b0; extra = 1'b0;
        for (int k = 0; k < 64 && cyc < 0; k++) begin
            @(posedge clk); #1;
            if (dataOutReady || dataInReady) begin
                cyc = k; dout = dataOut; e = err; prd = dataOutReady; pwr = dataInReady;
            end
        end
        read = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        extra = dataOutReady | dataInReady;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [23:0] addr;
        logic [1:0]  bc;
        logic [31:0] din;
        int          cyc;
        logic        exp_rd;
        logic        exp_err;
        logic [31:0] dout;
    } vec_t;

    vec_t vt [14];

    initial begin
        int          cyc, base, npl, np;
        int          pk [3];
        logic [31:0] dout, r0, r1;
        logic        e, prd, pwr, extra;

        //        rd    wr    addr         bc    din            cyc rd?   err   dout
        vt[0]  = '{1'b0, 1'b1, 24'h000010, 2'd3, 32'hDDCCBBAA, 5, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 24'h000010, 2'd3, 32'h0,        5, 1'b1, 1'b0, 32'hDDCCBBAA};
        vt[2]  = '{1'b0, 1'b1, 24'h0000FE, 2'd3, 32'hDDCCBBAA, 5, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 1'b0, 24'h000000, 2'd1, 32'h0,        3, 1'b1, 1'b0, 32'h0000DDCC};
        vt[4]  = '{1'b1, 1'b0, 24'h0000FE, 2'd3, 32'h0,        5, 1'b1, 1'b0, 32'hDDCCBBAA};
        vt[5]  = '{1'b1, 1'b0, 24'h0000FF, 2'd0, 32'h0,        2, 1'b1, 1'b0, 32'h000000BB};
        vt[6]  = '{1'b0, 1'b1, 24'h000105, 2'd0, 32'h000000EE, 2, 1'b0, 1'b1, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 24'h000300, 2'd3, 32'h0,        2, 1'b1, 1'b1, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 24'h0003FF, 2'd3, 32'h12345678, 2, 1'b0, 1'b1, 32'h0};
        vt[9]  = '{1'b1, 1'b1, 24'h000010, 2'd2, 32'h99999999, 4, 1'b1, 1'b0, 32'h00CCBBAA};
        vt[10] = '{1'b1, 1'b0, 24'h000011, 2'd0, 32'h0,        2, 1'b1, 1'b0, 32'h000000BB};
        vt[11] = '{1'b0, 1'b1, 24'h000011, 2'd1, 32'h00007766, 3, 1'b0, 1'b0, 32'h0};
        vt[12] = '{1'b1, 1'b0, 24'h000010, 2'd3, 32'h0,        5, 1'b1, 1'b0, 32'hDD7766AA};
        vt[13] = '{1'b1, 1'b0, 24'hFFFC10, 2'd1, 32'h0,        3, 1'b1, 1'b0, 32'h000066AA};

        for (int i = 0; i < 4; i++) rd_list[i] = 8'h00;
        read = 1'b0; write = 1'b0; address = '0; byteCount = '0; dataIn = '0;

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dataOut", dataOut, 32'h0);
        chk("rst_flags", {26'h0, dataOutReady, dataInReady, err, busy, io_re, io_we}, 32'h0);
        chk("rst_io", {16'h0, io_addr, io_wdata}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ROM byte before the rejected write
        txn(1'b1, 1'b0, 24'h000105, 2'd0, 32'h0, cyc, r0, e, prd, pwr, extra);
        chk("rom_rd_cycle", cyc, 2);
        chk("rom_rd_err", e, 1'b0);

        for (int i = 0; i < 14; i++) begin
            txn(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].bc, vt[i].din, cyc, dout, e, prd, pwr, extra);
            chk($sformatf("v%0d_cycle", i), cyc, vt[i].cyc);
            chk($sformatf("v%0d_kind", i), {30'h0, prd, pwr}, {30'h0, vt[i].exp_rd, !vt[i].exp_rd});
            chk($sformatf("v%0d_err", i), e, vt[i].exp_err);
            if (vt[i].exp_rd) chk($sformatf("v%0d_dout", i), dout, vt[i].dout);
            chk($sformatf("v%0d_oneshot", i), extra, 1'b0);
        end

        txn(1'b1, 1'b0, 24'h000105, 2'd0, 32'h0, cyc, r1, e, prd, pwr, extra);
        chk("rom_unchanged", r1, r0);

        // abort: drop write after two of four bytes
        txn(1'b0, 1'b1, 24'h000040, 2'd3, 32'h0, cyc, dout, e, prd, pwr, extra);
        address = 24'h000040; byteCount = 2'd3; dataIn = 32'h44332211; write = 1'b1;
        npl = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (dataOutReady || dataInReady) npl++;
        end
        write = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle", busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (dataOutReady || dataInReady) npl++;
            @(posedge clk); #1;
        end
        chk("abort_nopulse", npl, 0);
        txn(1'b1, 1'b0, 24'h000040, 2'd3, 32'h0, cyc, dout, e, prd, pwr, extra);
        chk("abort_sram", dout, 32'h00002211);

        // IO read, 3 wait cycles per byte
        io_wait = 3; rd_base = ack_n; base = ack_n;
        rd_list[0] = 8'h11; rd_list[1] = 8'h22;
        txn(1'b1, 1'b0, 24'h000204, 2'd1, 32'h0, cyc, dout, e, prd, pwr, extra);
        chk("io_rd_cycle", cyc, 10);
        chk("io_rd_dout", dout, 32'h00002211);
        chk("io_rd_err", e, 1'b0);
        chk("io_rd_acks", ack_n - base, 2);
        chk("io_rd_addr0", addr_log[base & 63], 8'h04);
        chk("io_rd_addr1", addr_log[(base + 1) & 63], 8'h05);

        // IO write, no wait, address wraps within the 256-byte window
        io_wait = 0; base = ack_n;
        txn(1'b0, 1'b1, 24'h0002FF, 2'd1, 32'h0000A55A, cyc, dout, e, prd, pwr, extra);
        chk("io_wr_cycle", cyc, 4);
        chk("io_wr_kind", {30'h0, prd, pwr}, 32'h1);
        chk("io_wr_addr0", addr_log[base & 63], 8'hFF);
        chk("io_wr_addr1", addr_log[(base + 1) & 63], 8'h00);
        chk("io_wr_data0", wd_log[base & 63], 8'h5A);
        chk("io_wr_data1", wd_log[(base + 1) & 63], 8'hA5);

        // IO timeout: ack never comes
        io_wait = 1000;
        txn(1'b1, 1'b0, 24'h000210, 2'd0, 32'h000000C3, cyc, dout, e, prd, pwr, extra);
        chk("io_to_cycle", cyc, 16);
        chk("io_to_err", e, 1'b1);
        chk("io_to_kind", {30'h0, prd, pwr}, 32'h2);
        io_wait = 0;
        @(posedge clk); #1;

        // reset in the middle of a read
        address = 24'h000010; byteCount = 2'd3; read = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_busy_before", busy, 1'b1);
        rst = 1'b1; read = 1'b0;
        @(posedge clk); #1;
        chk("midrst_dataOut", dataOut, 32'h0);
        chk("midrst_flags", {26'h0, dataOutReady, dataInReady, err, busy, io_re, io_we}, 32'h0);
        chk("midrst_io", {16'h0, io_addr, io_wdata}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // continuous read: pulses byteCount+4 apart
        address = 24'h000010; byteCount = 2'd1; read = 1'b1; np = 0;
        for (int k = 0; k < 3; k++) pk[k] = -100;
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            if (dataOutReady) begin
                if (np < 3) pk[np] = k;
                np++;
            end
        end
        read = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("cont_count", np, 3);
        chk("cont_first", pk[0], 3);
        chk("cont_gap1", pk[1] - pk[0], 5);
        chk("cont_gap2", pk[2] - pk[1], 5);

        chk("err_only_with_pulse", orphan, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
